// File: rtl/counter_pkg.sv
// Shared types and the step helper for the programmable counter.
// The helper works on a fixed 64-bit container, so counters up to 64 bits wide are supported.
package counter_pkg;

    localparam int MAX_WIDTH = 64;

    typedef logic [MAX_WIDTH-1:0] cnt_t;

    typedef enum logic [1:0] {
        MODE_WRAP     = 2'd0,
        MODE_SATURATE = 2'd1,
        MODE_ONESHOT  = 2'd2,
        MODE_WRAP_ALT = 2'd3
    } mode_t;

    typedef enum logic [1:0] {
        OS_IDLE = 2'd0,
        OS_RUN  = 2'd1,
        OS_DONE = 2'd2
    } os_state_t;

    // One step toward the terminal value. A count above limit is treated as
    // already at terminal on an up-step.
    function automatic cnt_t next_count(
        input cnt_t count,
        input cnt_t limit,
        input logic dir,
        input logic saturate
    );
        cnt_t result;
        if (dir) begin
            if (count >= limit) begin
                result = saturate ? limit : '0;
            end else begin
                result = count + cnt_t'(1);
            end
        end else begin
            if (count == '0) begin
                result = saturate ? '0 : limit;
            end else begin
                result = count - cnt_t'(1);
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/prog_counter_fsm.sv
// One-shot sequencer: IDLE -> RUN -> DONE -> IDLE, with a restart allowed from DONE.
// Produces the start-point load strobe for the datapath plus registered busy/done.
module prog_counter_fsm
    import counter_pkg::*;
(
    input  logic      i_clk,
    input  logic      i_rst_n,
    input  logic      i_clear,
    input  logic      i_load,
    input  logic      i_oneshot,
    input  logic      i_start,
    input  logic      i_en,
    input  logic      i_reach,
    output os_state_t o_state,
    output logic      o_start_stb,
    output logic      o_busy,
    output logic      o_done
);

    os_state_t state_q, state_d;
    logic      busy_q, busy_d;
    logic      done_q, done_d;
    logic      start_stb;

    always_comb begin
        state_d   = state_q;
        done_d    = 1'b0;
        start_stb = 1'b0;
        if (i_clear || !i_oneshot) begin
            // Leaving one-shot mode abandons the run silently.
            state_d = OS_IDLE;
        end else begin
            case (state_q)
                OS_IDLE: begin
                    if (i_start && !i_load) begin
                        state_d   = OS_RUN;
                        start_stb = 1'b1;
                    end
                end
                OS_RUN: begin
                    if (!i_load && i_en && i_reach) begin
                        state_d = OS_DONE;
                        done_d  = 1'b1;
                    end
                end
                OS_DONE: begin
                    if (i_start && !i_load) begin
                        state_d   = OS_RUN;
                        start_stb = 1'b1;
                    end else begin
                        state_d = OS_IDLE;
                    end
                end
                default: state_d = OS_IDLE;
            endcase
        end
        busy_d = (state_d != OS_IDLE);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= OS_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign o_state     = state_q;
    assign o_start_stb = start_stb;
    assign o_busy      = busy_q;
    assign o_done      = done_q;

endmodule

// File: rtl/prog_counter.sv
// Programmable up/down counter with wrap, saturate and one-shot modes.
// Priority each cycle: clear > load > start > enabled step. All outputs registered.
module prog_counter
    import counter_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_clear,
    input  logic             i_en,
    input  logic             i_dir,
    input  mode_t            i_mode,
    input  logic [WIDTH-1:0] i_limit,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_value,
    input  logic             i_start,
    output logic [WIDTH-1:0] o_count,
    output logic             o_tc,
    output logic             o_busy,
    output logic             o_done
);

    logic [WIDTH-1:0] count_q, count_d;
    logic             tc_q, tc_d;

    cnt_t             count_ext, limit_ext, term_ext, step_ext;
    logic             oneshot, sat_step, at_term, reach;
    logic [WIDTH-1:0] load_clamped, start_point;
    os_state_t        os_state;
    logic             start_stb;

    always_comb begin
        oneshot      = (i_mode == MODE_ONESHOT);
        sat_step     = oneshot || (i_mode == MODE_SATURATE);
        count_ext    = cnt_t'(count_q);
        limit_ext    = cnt_t'(i_limit);
        term_ext     = i_dir ? limit_ext : '0;
        step_ext     = next_count(count_ext, limit_ext, i_dir, sat_step);
        at_term      = i_dir ? (count_ext >= limit_ext) : (count_ext == '0);
        reach        = (step_ext == term_ext);
        load_clamped = (i_load_value > i_limit) ? i_limit : i_load_value;
        start_point  = i_dir ? '0 : i_limit;
    end

    prog_counter_fsm u_fsm (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_clear     (i_clear),
        .i_load      (i_load),
        .i_oneshot   (oneshot),
        .i_start     (i_start),
        .i_en        (i_en),
        .i_reach     (reach),
        .o_state     (os_state),
        .o_start_stb (start_stb),
        .o_busy      (o_busy),
        .o_done      (o_done)
    );

    always_comb begin
        count_d = count_q;
        tc_d    = 1'b0;
        if (i_clear) begin
            count_d = '0;
        end else if (i_load) begin
            count_d = load_clamped;
        end else if (oneshot) begin
            if (start_stb) begin
                count_d = start_point;
            end else if (os_state == OS_RUN && i_en) begin
                count_d = step_ext[WIDTH-1:0];
                tc_d    = reach;
            end
        end else if (os_state == OS_IDLE && i_en) begin
            // A one-shot run still unwinding after a mode change holds the count.
            count_d = step_ext[WIDTH-1:0];
            if (sat_step) begin
                tc_d = reach && (count_ext != term_ext);
            end else begin
                tc_d = at_term;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            count_q <= '0;
            tc_q    <= 1'b0;
        end else begin
            count_q <= count_d;
            tc_q    <= tc_d;
        end
    end

    assign o_count = count_q;
    assign o_tc    = tc_q;

endmodule

// File: tb/tb_prog_counter.sv
// Directed scenarios plus a randomized run against a behavioural reference model.
module tb_prog_counter;
    import counter_pkg::*;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         clear = 1'b0;
    logic         en = 1'b0;
    logic         dir = 1'b1;
    mode_t        mode = MODE_WRAP;
    logic [W-1:0] limit = '0;
    logic         load = 1'b0;
    logic [W-1:0] load_value = '0;
    logic         start = 1'b0;
    logic [W-1:0] count;
    logic         tc, busy, done;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: integer count plus "running" / "finishing" flags.
    int m_cnt = 0;
    bit m_run = 0, m_fin = 0, m_tc = 0, m_done = 0;

    prog_counter #(.WIDTH(W)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_clear      (clear),
        .i_en         (en),
        .i_dir        (dir),
        .i_mode       (mode),
        .i_limit      (limit),
        .i_load       (load),
        .i_load_value (load_value),
        .i_start      (start),
        .o_count      (count),
        .o_tc         (tc),
        .o_busy       (busy),
        .o_done       (done)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    task automatic model_edge();
        int lim = int'(limit);
        int lv  = int'(load_value);
        int term = dir ? lim : 0;
        m_tc = 0;
        m_done = 0;
        if (clear) begin
            m_cnt = 0; m_run = 0; m_fin = 0;
        end else if (load) begin
            m_cnt = (lv > lim) ? lim : lv;
            m_fin = 0;
            if (mode != MODE_ONESHOT) m_run = 0;
        end else if (mode == MODE_ONESHOT) begin
            if (!m_run && start) begin
                m_cnt = dir ? 0 : lim; m_run = 1; m_fin = 0;
            end else if (m_fin) begin
                m_fin = 0;
            end else if (m_run && en) begin
                if (dir) m_cnt = (m_cnt >= lim) ? lim : m_cnt + 1;
                else     m_cnt = (m_cnt == 0) ? 0 : m_cnt - 1;
                if (m_cnt == term) begin
                    m_tc = 1; m_done = 1; m_run = 0; m_fin = 1;
                end
            end
        end else if (m_run || m_fin) begin
            m_run = 0; m_fin = 0;
        end else if (en) begin
            if (mode == MODE_SATURATE) begin
                if (dir) begin
                    if (m_cnt >= lim) begin m_tc = (m_cnt != lim); m_cnt = lim; end
                    else begin m_cnt = m_cnt + 1; m_tc = (m_cnt == lim); end
                end else if (m_cnt != 0) begin
                    m_cnt = m_cnt - 1; m_tc = (m_cnt == 0);
                end
            end else begin
                if (dir) begin
                    if (m_cnt >= lim) begin m_cnt = 0; m_tc = 1; end
                    else m_cnt = m_cnt + 1;
                end else begin
                    if (m_cnt == 0) begin m_cnt = lim; m_tc = 1; end
                    else m_cnt = m_cnt - 1;
                end
            end
        end
    endtask

    task automatic clk_step();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        $display("reset     count=%0d tc=%0b busy=%0b done=%0b", count, tc, busy, done);
        n_cmp++; if (count !== '0) begin n_err++; $display("FAIL reset_count got %0d expected 0", count); end
        n_cmp++; if (tc !== 1'b0) begin n_err++; $display("FAIL reset_tc got %0b expected 0", tc); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %0b expected 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done got %0b expected 0", done); end
        m_cnt = 0; m_run = 0; m_fin = 0; m_tc = 0; m_done = 0;
        rst_n = 1'b1;
    endtask

    task automatic test_wrap_up();
        int exp_c[7] = '{1, 2, 3, 4, 0, 1, 2};
        bit exp_t[7] = '{0, 0, 0, 0, 1, 0, 0};
        mode = MODE_WRAP; limit = 4; dir = 1'b1; en = 1'b1;
        for (int i = 0; i < 7; i++) begin
            clk_step();
            $display("wrap_up   step=%0d count=%0d tc=%0b", i, count, tc);
            n_cmp++; if (count !== W'(exp_c[i])) begin n_err++; $display("FAIL wrap_up_count step %0d got %0d expected %0d", i, count, exp_c[i]); end
            n_cmp++; if (tc !== exp_t[i]) begin n_err++; $display("FAIL wrap_up_tc step %0d got %0b expected %0b", i, tc, exp_t[i]); end
        end
        en = 1'b0;
    endtask

    task automatic test_wrap_down();
        int exp_c[6] = '{4, 3, 2, 1, 0, 4};
        bit exp_t[6] = '{1, 0, 0, 0, 0, 1};
        clear = 1'b1; clk_step(); clear = 1'b0;
        mode = MODE_WRAP; limit = 4; dir = 1'b0; en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            clk_step();
            $display("wrap_dn   step=%0d count=%0d tc=%0b", i, count, tc);
            n_cmp++; if (count !== W'(exp_c[i])) begin n_err++; $display("FAIL wrap_dn_count step %0d got %0d expected %0d", i, count, exp_c[i]); end
            n_cmp++; if (tc !== exp_t[i]) begin n_err++; $display("FAIL wrap_dn_tc step %0d got %0b expected %0b", i, tc, exp_t[i]); end
        end
        en = 1'b0;
    endtask

    task automatic test_saturate();
        int exp_c[6] = '{1, 2, 3, 3, 3, 3};
        bit exp_t[6] = '{0, 0, 1, 0, 0, 0};
        clear = 1'b1; clk_step(); clear = 1'b0;
        mode = MODE_SATURATE; limit = 3; dir = 1'b1; en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            clk_step();
            $display("saturate  step=%0d count=%0d tc=%0b", i, count, tc);
            n_cmp++; if (count !== W'(exp_c[i])) begin n_err++; $display("FAIL sat_count step %0d got %0d expected %0d", i, count, exp_c[i]); end
            n_cmp++; if (tc !== exp_t[i]) begin n_err++; $display("FAIL sat_tc step %0d got %0b expected %0b", i, tc, exp_t[i]); end
        end
        limit = 1;
        clk_step();
        $display("saturate  lowered limit count=%0d", count);
        n_cmp++; if (count !== W'(1)) begin n_err++; $display("FAIL sat_lowered_limit got %0d expected 1", count); end
        en = 1'b0;
    endtask

    task automatic test_oneshot();
        clear = 1'b1; clk_step(); clear = 1'b0;
        mode = MODE_ONESHOT; limit = 3; dir = 1'b1;
        start = 1'b1; clk_step(); start = 1'b0;
        $display("oneshot   start count=%0d busy=%0b done=%0b", count, busy, done);
        n_cmp++; if (count !== W'(0) || busy !== 1'b1 || done !== 1'b0) begin n_err++; $display("FAIL os_start got count=%0d busy=%0b done=%0b expected 0/1/0", count, busy, done); end
        en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (i == 1) start = 1'b1;
            clk_step();
            start = 1'b0;
            $display("oneshot   step=%0d count=%0d tc=%0b busy=%0b done=%0b", i, count, tc, busy, done);
            n_cmp++; if (count !== W'(i + 1)) begin n_err++; $display("FAIL os_count step %0d got %0d expected %0d", i, count, i + 1); end
            n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL os_busy step %0d got %0b expected 1", i, busy); end
            n_cmp++; if (done !== (i == 2)) begin n_err++; $display("FAIL os_done step %0d got %0b expected %0b", i, done, (i == 2)); end
            n_cmp++; if (tc !== (i == 2)) begin n_err++; $display("FAIL os_tc step %0d got %0b expected %0b", i, tc, (i == 2)); end
        end
        clk_step();
        $display("oneshot   after done count=%0d busy=%0b done=%0b", count, busy, done);
        n_cmp++; if (count !== W'(3) || busy !== 1'b0 || done !== 1'b0) begin n_err++; $display("FAIL os_idle got count=%0d busy=%0b done=%0b expected 3/0/0", count, busy, done); end
        // Zero limit: start point is already terminal.
        limit = 0;
        start = 1'b1; clk_step(); start = 1'b0;
        clk_step();
        $display("oneshot   limit0 count=%0d tc=%0b busy=%0b done=%0b", count, tc, busy, done);
        n_cmp++; if (done !== 1'b1 || tc !== 1'b1 || busy !== 1'b1) begin n_err++; $display("FAIL os_limit0 got tc=%0b busy=%0b done=%0b expected 1/1/1", tc, busy, done); end
        clk_step();
        n_cmp++; if (busy !== 1'b0 || done !== 1'b0) begin n_err++; $display("FAIL os_limit0_idle got busy=%0b done=%0b expected 0/0", busy, done); end
        // Mode change mid-run aborts without a done pulse.
        limit = 3;
        start = 1'b1; clk_step(); start = 1'b0;
        clk_step();
        mode = MODE_WRAP;
        clk_step();
        $display("oneshot   abort count=%0d busy=%0b done=%0b", count, busy, done);
        n_cmp++; if (count !== W'(1) || busy !== 1'b0 || done !== 1'b0) begin n_err++; $display("FAIL os_abort got count=%0d busy=%0b done=%0b expected 1/0/0", count, busy, done); end
        en = 1'b0;
    endtask

    task automatic test_priority();
        mode = MODE_WRAP; limit = 5; dir = 1'b1; en = 1'b1;
        clear = 1'b1; load = 1'b1; load_value = 7;
        clk_step();
        clear = 1'b0;
        $display("priority  clear+load+en count=%0d", count);
        n_cmp++; if (count !== W'(0)) begin n_err++; $display("FAIL prio_clear got %0d expected 0", count); end
        load_value = 9;
        clk_step();
        $display("priority  load clamp count=%0d tc=%0b", count, tc);
        n_cmp++; if (count !== W'(5) || tc !== 1'b0) begin n_err++; $display("FAIL prio_load_clamp got count=%0d tc=%0b expected 5/0", count, tc); end
        load = 1'b0; en = 1'b0;
        mode = MODE_ONESHOT;
        start = 1'b1; clk_step(); start = 1'b0;
        en = 1'b1; load = 1'b1; load_value = 2;
        clk_step();
        load = 1'b0;
        $display("priority  load in run count=%0d busy=%0b", count, busy);
        n_cmp++; if (count !== W'(2) || busy !== 1'b1) begin n_err++; $display("FAIL prio_load_run got count=%0d busy=%0b expected 2/1", count, busy); end
        clk_step();
        n_cmp++; if (count !== W'(3) || busy !== 1'b1) begin n_err++; $display("FAIL prio_run_after_load got count=%0d busy=%0b expected 3/1", count, busy); end
        en = 1'b0;
    endtask

    task automatic test_async_reset();
        clear = 1'b1; clk_step(); clear = 1'b0;
        mode = MODE_ONESHOT; limit = 10; dir = 1'b1; en = 1'b1;
        start = 1'b1; clk_step(); start = 1'b0;
        clk_step(); clk_step();
        #2 rst_n = 1'b0;
        #1;
        $display("async_rst count=%0d tc=%0b busy=%0b done=%0b", count, tc, busy, done);
        n_cmp++; if (count !== '0 || tc !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin n_err++; $display("FAIL async_reset got count=%0d tc=%0b busy=%0b done=%0b expected all 0", count, tc, busy, done); end
        m_cnt = 0; m_run = 0; m_fin = 0; m_tc = 0; m_done = 0;
        @(posedge clk); #1 rst_n = 1'b1;
        clk_step();
        $display("async_rst released count=%0d busy=%0b", count, busy);
        n_cmp++; if (count !== W'(0) || busy !== 1'b0) begin n_err++; $display("FAIL async_release got count=%0d busy=%0b expected 0/0", count, busy); end
        en = 1'b0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            clear = ($urandom_range(0, 31) == 0);
            load  = ($urandom_range(0, 15) == 0);
            en    = ($urandom_range(0, 3) != 0);
            start = en && ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 7) == 0) dir = ~dir;
            if ($urandom_range(0, 19) == 0) mode = mode_t'($urandom_range(0, 3));
            if ($urandom_range(0, 24) == 0) limit = W'($urandom_range(0, 15));
            load_value = W'($urandom_range(0, 20));
            clk_step();
            $display("random    cyc=%0d count=%0d tc=%0b busy=%0b done=%0b", i, count, tc, busy, done);
            n_cmp++; if (count !== W'(m_cnt)) begin n_err++; $display("FAIL rand_count cyc %0d got %0d expected %0d", i, count, m_cnt); end
            n_cmp++; if (tc !== m_tc) begin n_err++; $display("FAIL rand_tc cyc %0d got %0b expected %0b", i, tc, m_tc); end
            n_cmp++; if (busy !== (m_run || m_fin)) begin n_err++; $display("FAIL rand_busy cyc %0d got %0b expected %0b", i, busy, (m_run || m_fin)); end
            n_cmp++; if (done !== m_done) begin n_err++; $display("FAIL rand_done cyc %0d got %0b expected %0b", i, done, m_done); end
        end
        clear = 1'b0; load = 1'b0; en = 1'b0; start = 1'b0;
    endtask

    initial begin
        test_reset();
        test_wrap_up();
        test_wrap_down();
        test_saturate();
        test_oneshot();
        test_priority();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
